regfile_2w2r_sb: RTL
====================

Name: regfile_2w2r_sb

Overview:
- Parametrised successor of the single-write register file for the MIPS datapath.
- Generalised in data width and depth, with two write ports: port 0 for ALU writeback, port 1 for load/memory writeback.
- Two combinational read ports, with optional same-cycle write-to-read bypass.
- Per-register pending scoreboard so the decode stage can detect load-use hazards and stall.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- ZERO_REG, 1, if 1 then register 0 reads as 0, ignores writes and is never marked pending.
- BYPASS, 1, if 1 then a read returns same-cycle write data on an address match.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we0  in  1  write enable, port 0.
- waddr0  in  ADDR_W  write address, port 0.
- wdata0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1.
- waddr1  in  ADDR_W  write address, port 1.
- wdata1  in  DATA_W  write data, port 1.
- raddr0  in  ADDR_W  read address A.
- rdata0  out  DATA_W  read data A.
- rbusy0  out  1  register at raddr0 is pending.
- raddr1  in  ADDR_W  read address B.
- rdata1  out  DATA_W  read data B.
- rbusy1  out  1  register at raddr1 is pending.
- pend_set  in  1  mark register pend_addr as awaiting writeback.
- pend_addr  in  ADDR_W  register to mark.
- pend_cnt  out  ADDR_W+1  number of pending registers.
- pend_full  out  1  high when every markable register is pending.

Behaviour:
- One clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (rst_n=0, asynchronous):
  - All registers cleared to 0.
  - All pending bits cleared; pend_cnt=0.
  - rdata0/1 read 0; rbusy0/1=0.
  - Writes and pend_set are ignored while reset is asserted.
- Writes:
  - Registered on the rising clk edge.
  - If we0 and we1 target the same address, port 1 wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Reads:
  - Combinational, zero latency.
  - With ZERO_REG=1, address 0 returns 0.
  - With BYPASS=1, an effective write to raddr in the same cycle returns that write's data instead of array contents; port 1 has priority.
  - With BYPASS=0, the new value is visible from the cycle after the write.
- Pending scoreboard, one bit per register:
  - Any effective write (we0 or we1) clears the bit for its address at the clock edge.
  - pend_set sets the bit for pend_addr at the clock edge.
  - pend_set and a write to the same address in the same cycle: the set wins, because a new producer is issued. Register data is still updated.
  - pend_set on an already-pending register: no change; the count does not increment.
  - Clearing a non-pending register: no change.
  - With ZERO_REG=1, pend_set to address 0 is ignored.
- rbusy:
  - rbusyN = pending[raddrN].
  - With BYPASS=1, rbusyN is forced to 0 when a same-cycle write to raddrN occurs and there is no same-cycle pend_set to that address.
  - With ZERO_REG=1, rbusyN is 0 for address 0.
- pend_cnt:
  - Registered; equals the population of the pending bits after each edge.
  - May change by -2..+1 per cycle (two clears, one set).
  - Maintained incrementally; it must never wrap.
- pend_full = (pend_cnt == 2**ADDR_W - ZERO_REG), combinational from pend_cnt.
- pend_set while pend_full is legal but has no effect, because every markable register is already pending.

Decomposition:
- Shared package regfile_pkg:
  - defaults DATA_W_DEF=32 and ADDR_W_DEF=5;
  - constant REG_ZERO=0;
  - localparam DEPTH=2**ADDR_W.
- Sub-module regfile_scoreboard holds the pending bits, pend_cnt and pend_full; the top level keeps the array, write arbitration and bypass muxes.

Test Plan:
- Reset then read: rst_n=0 for 2 cycles, release → rdata0/1 = 0 for all 32 addresses; pend_cnt=0.
- Dual write same address: we0/waddr0=5/wdata0=0x11, we1/waddr1=5/wdata1=0x22 → next cycle rdata0(raddr0=5)=0x22.
- Bypass: write 0xDEADBEEF to r7 on port 0; same cycle raddr1=7 → rdata1=0xDEADBEEF that cycle with BYPASS=1, and the old value 0 with BYPASS=0.
- Scoreboard: pend_set r3 → rbusy0(raddr0=3)=1, pend_cnt=1. Then a we1 write to r3 → same cycle rbusy0=0 (BYPASS=1). Next edge: pend_cnt=0.
- Simultaneous set and clear: r9 pending, then pend_set r9 plus we0 to r9 in one cycle → r9 stays pending, pend_cnt unchanged, data updated. Also: pend_set r0 and a write 0x55 to r0 → r0 reads 0, pend_cnt unchanged.
- Full and async reset mid-run: pend_set r1..r31 → pend_cnt=31, pend_full=1. Then rst_n pulse low mid-cycle → pend_cnt=0 and rbusy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the dual-write register file and its scoreboard.
//
// Contents:
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width.
//   REG_ZERO                : index of the hard-wired zero register.
//   DEPTH_DEF               : default number of registers.
//   depth_of()              : number of registers for a given address width.
//   markable_regs()         : number of registers that can ever be pending.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;
    localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Register 0 can never be pending when it is hard-wired to zero.
    function automatic int markable_regs(input int addr_w, input int zero_reg);
        return (1 << addr_w) - ((zero_reg != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-writeback scoreboard: one bit per register plus a running count.
//
// Ports:
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset.
//   clr0_en / clr0_addr   : effective write on port 0, clears that pending bit.
//   clr1_en / clr1_addr   : effective write on port 1, clears that pending bit.
//   set_en / set_addr     : mark a register as awaiting writeback.
//   raddr0 / raddr1       : lookup addresses.
//   busy0 / busy1         : raw pending bit at raddr0 / raddr1.
//   pend_cnt              : number of pending registers (registered).
//   pend_full             : every markable register is pending.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr0_en,
    input  logic [ADDR_W-1:0] clr0_addr,
    input  logic              clr1_en,
    input  logic [ADDR_W-1:0] clr1_addr,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic              busy0,
    output logic              busy1,
    output logic [ADDR_W:0]   pend_cnt,
    output logic              pend_full
);

    localparam int            DEPTH    = depth_of(ADDR_W);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(markable_regs(ADDR_W, ZERO_REG));

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [ADDR_W:0]  cnt_q;
    logic [ADDR_W:0]  cnt_d;
    logic             set_ok;
    logic             set_new;
    logic             clr0_hit;
    logic             clr1_hit;

    always_comb begin
        set_ok = set_en && !((ZERO_REG != 0) && (set_addr == ADDR_W'(REG_ZERO)));

        // Each term counts an actual 0->1 or 1->0 transition, so the count
        // tracks the population exactly and cannot wrap. A clear that
        // collides with a set is overridden by the set; two clears of the
        // same register count once.
        set_new  = set_ok && !pend_q[set_addr];
        clr0_hit = clr0_en && pend_q[clr0_addr]
                   && !(set_ok && (set_addr == clr0_addr));
        clr1_hit = clr1_en && pend_q[clr1_addr]
                   && !(set_ok && (set_addr == clr1_addr))
                   && !(clr0_en && (clr0_addr == clr1_addr));

        pend_d = pend_q;
        if (clr0_en) pend_d[clr0_addr] = 1'b0;
        if (clr1_en) pend_d[clr1_addr] = 1'b0;
        if (set_ok)  pend_d[set_addr]  = 1'b1;

        cnt_d = cnt_q
              + {{ADDR_W{1'b0}}, set_new}
              - {{ADDR_W{1'b0}}, clr0_hit}
              - {{ADDR_W{1'b0}}, clr1_hit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy0     = pend_q[raddr0];
    assign busy1     = pend_q[raddr1];
    assign pend_cnt  = cnt_q;
    assign pend_full = (cnt_q == FULL_CNT);

endmodule

// File: rtl/regfile_2w2r_sb.sv
// Two-write / two-read register file with pending-writeback scoreboard.
// Port 0 carries ALU writeback, port 1 carries load writeback; port 1 wins
// on an address collision. Reads are combinational with optional same-cycle
// write bypass.
//
// Ports:
//   clk, rst_n                 : clock (rising edge), async active-low reset.
//   we0, waddr0, wdata0        : write port 0.
//   we1, waddr1, wdata1        : write port 1.
//   raddr0 -> rdata0, rbusy0   : read port A and its pending flag.
//   raddr1 -> rdata1, rbusy1   : read port B and its pending flag.
//   pend_set, pend_addr        : mark a register as awaiting writeback.
//   pend_cnt, pend_full        : pending population and full flag.
module regfile_2w2r_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rbusy0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rbusy1,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic [ADDR_W:0]   pend_cnt,
    output logic              pend_full
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wen0;
    logic              wen1;
    logic              set_live;
    logic              sb_busy0;
    logic              sb_busy1;
    logic [ADDR_W-1:0] raddr_a [2];
    logic              busy_raw [2];
    logic [DATA_W-1:0] rdata_a [2];
    logic              rbusy_a [2];

    // Effective write enables. Gating with rst_n keeps the bypass path from
    // leaking write data onto the read ports while reset is held.
    always_comb begin
        wen0     = we0 && rst_n && !((ZERO_REG != 0) && (waddr0 == ADDR_W'(REG_ZERO)));
        wen1     = we1 && rst_n && !((ZERO_REG != 0) && (waddr1 == ADDR_W'(REG_ZERO)));
        set_live = pend_set && rst_n;
    end

    // Port 1 is applied last so it wins on a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wen0) mem[waddr0] <= wdata0;
            if (wen1) mem[waddr1] <= wdata1;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr0_en   (wen0),
        .clr0_addr (waddr0),
        .clr1_en   (wen1),
        .clr1_addr (waddr1),
        .set_en    (set_live),
        .set_addr  (pend_addr),
        .raddr0    (raddr0),
        .raddr1    (raddr1),
        .busy0     (sb_busy0),
        .busy1     (sb_busy1),
        .pend_cnt  (pend_cnt),
        .pend_full (pend_full)
    );

    assign raddr_a[0]  = raddr0;
    assign raddr_a[1]  = raddr1;
    assign busy_raw[0] = sb_busy0;
    assign busy_raw[1] = sb_busy1;

    // Read muxes. A same-cycle write to the read address also forwards
    // "not busy" unless a new producer is being issued to it this cycle.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata_a[p] = mem[raddr_a[p]];
            rbusy_a[p] = busy_raw[p];
            if (BYPASS != 0) begin
                if (wen1 && (waddr1 == raddr_a[p])) begin
                    rdata_a[p] = wdata1;
                end else if (wen0 && (waddr0 == raddr_a[p])) begin
                    rdata_a[p] = wdata0;
                end
                if (((wen0 && (waddr0 == raddr_a[p])) || (wen1 && (waddr1 == raddr_a[p])))
                    && !(set_live && (pend_addr == raddr_a[p]))) begin
                    rbusy_a[p] = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (raddr_a[p] == ADDR_W'(REG_ZERO))) begin
                rdata_a[p] = '0;
                rbusy_a[p] = 1'b0;
            end
        end
    end

    assign rdata0 = rdata_a[0];
    assign rdata1 = rdata_a[1];
    assign rbusy0 = rbusy_a[0];
    assign rbusy1 = rbusy_a[1];

endmodule
